// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: control-bus bit positions and FSM encoding.
package mem_stage_pkg;

  // mem_ctrl_i bit positions
  localparam int MEM_BRANCH = 0;
  localparam int MEM_READ   = 1;
  localparam int MEM_WRITE  = 2;
  localparam int MEM_BNE    = 3;

  // wb_ctrl_i bit positions
  localparam int WB_MEMTOREG = 0;
  localparam int WB_REGWRITE = 1;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_stage_memwb.sv
// MEM/WB pipeline register. A bubble zeroes the control field and holds
// the data fields; otherwise all fields capture, with load data only
// captured when rdEn marks a completed load.
module mem_stage_memwb #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble,
  input  logic [1:0]        wbIn,
  input  logic [DATA_W-1:0] aluIn,
  input  logic [4:0]        regIn,
  input  logic              rdEn,
  input  logic [DATA_W-1:0] rdIn,
  output logic [1:0]        wbQ,
  output logic [DATA_W-1:0] rdQ,
  output logic [DATA_W-1:0] aluQ,
  output logic [4:0]        regQ
);

  // bubble / capture register update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbQ  <= '0;
      rdQ  <= '0;
      aluQ <= '0;
      regQ <= '0;
    end else if (bubble) begin
      wbQ <= '0;
    end else begin
      wbQ  <= wbIn;
      aluQ <= aluIn;
      regQ <= regIn;
      if (rdEn) rdQ <= rdIn;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory req/ready handshake, upstream stall, misaligned
// access trap, branch resolution and the MEM/WB register.
// Optional feature macro: MEM_TIMEOUT_EN -- aborts a WAIT that lasts
// TIMEOUT_CYC cycles, pulsing bus_err_o. Without it WAIT never times out.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        mem_ctrl_i,
  input  logic [1:0]        wb_ctrl_i,
  input  logic              equal_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [4:0]        wr_reg_i,
  input  logic [DATA_W-1:0] target_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ready_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              stall_o,
  output logic              pcsrc_o,
  output logic [DATA_W-1:0] pc_target_o,
  output logic              align_exc_o,
  output logic              bus_err_o,
  output logic [1:0]        wb_ctrl_q,
  output logic [DATA_W-1:0] rd_data_q,
  output logic [DATA_W-1:0] alu_q,
  output logic [4:0]        wr_reg_q
);

  // the wait counter is 5 bits wide
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32) begin : gBadTimeout
    $error("TIMEOUT_CYC must be in 2..32");
  end

  state_t state;
  logic   access, misaligned, req, stall, abort, alignExc;

  assign access     = mem_ctrl_i[MEM_READ] | mem_ctrl_i[MEM_WRITE];
  assign misaligned = access & (result_i[1:0] != 2'b00);
  // rst_n gates the request so an outstanding access is dropped the
  // instant reset asserts, not at the next edge
  assign req        = rst_n & access & ~misaligned & ~abort;
  assign stall      = req & ~dmem_ready_i;

`ifdef MEM_TIMEOUT_EN
  logic [4:0] waitCnt;
  logic       busErr;

  assign abort     = (state == WAIT) & access & ~misaligned & ~dmem_ready_i &
                     (waitCnt == 5'(TIMEOUT_CYC - 1));
  assign bus_err_o = busErr;

  // handshake FSM with wait counter; abort returns to IDLE and flags a bus error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      waitCnt <= '0;
      busErr  <= 1'b0;
    end else begin
      busErr <= 1'b0;
      case (state)
        IDLE: if (stall) begin
          state   <= WAIT;
          waitCnt <= '0;
        end
        WAIT: if (abort) begin
          state  <= IDLE;
          busErr <= 1'b1;
        end else if (!stall) begin
          state <= IDLE;
        end else begin
          waitCnt <= waitCnt + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign abort     = 1'b0;
  assign bus_err_o = 1'b0;

  // handshake FSM: WAIT while the request is unanswered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (stall)  state <= WAIT;
        WAIT:    if (!stall) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`endif

  // misaligned access is reported one cycle later as a single pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alignExc <= 1'b0;
    else        alignExc <= misaligned;
  end

  assign dmem_req_o   = req;
  assign dmem_we_o    = mem_ctrl_i[MEM_WRITE];   // read+write resolves to write
  assign dmem_addr_o  = result_i;
  assign dmem_wdata_o = store_data_i;
  assign stall_o      = stall;
  assign align_exc_o  = alignExc;
  assign pcsrc_o      = mem_ctrl_i[MEM_BRANCH] & (equal_i ^ mem_ctrl_i[MEM_BNE]) & ~stall;
  assign pc_target_o  = target_i;

  mem_stage_memwb #(.DATA_W(DATA_W)) uMemwb (
    .clk    (clk),
    .rst_n  (rst_n),
    .bubble (stall | abort),
    .wbIn   (misaligned ? 2'b00 : wb_ctrl_i),
    .aluIn  (result_i),
    .regIn  (wr_reg_i),
    .rdEn   (mem_ctrl_i[MEM_READ] & ~mem_ctrl_i[MEM_WRITE] & ~misaligned),
    .rdIn   (dmem_rdata_i),
    .wbQ    (wb_ctrl_q),
    .rdQ    (rd_data_q),
    .aluQ   (alu_q),
    .regQ   (wr_reg_q)
  );

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed cases, a mid-WAIT reset, a
// randomized instruction stream, and (with MEM_TIMEOUT_EN) a timeout.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  mem_ctrl_i;
  logic [1:0]  wb_ctrl_i;
  logic        equal_i;
  logic [31:0] result_i, store_data_i, target_i, dmem_rdata_i;
  logic [4:0]  wr_reg_i;
  logic        dmem_ready_i;
  logic        dmem_req_o, dmem_we_o, stall_o, pcsrc_o, align_exc_o, bus_err_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o, pc_target_o, rd_data_q, alu_q;
  logic [1:0]  wb_ctrl_q;
  logic [4:0]  wr_reg_q;

  always #5 clk = ~clk;

  mem_stage #(.DATA_W(32), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ctrl_i(mem_ctrl_i), .wb_ctrl_i(wb_ctrl_i),
    .equal_i(equal_i), .result_i(result_i), .store_data_i(store_data_i),
    .wr_reg_i(wr_reg_i), .target_i(target_i), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ready_i(dmem_ready_i), .dmem_rdata_i(dmem_rdata_i), .stall_o(stall_o),
    .pcsrc_o(pcsrc_o), .pc_target_o(pc_target_o), .align_exc_o(align_exc_o),
    .bus_err_o(bus_err_o), .wb_ctrl_q(wb_ctrl_q), .rd_data_q(rd_data_q),
    .alu_q(alu_q), .wr_reg_q(wr_reg_q)
  );

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  rg;
    logic        al;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  bit   monEn = 0;

  // reference MEM/WB contents
  logic [1:0]  mWb;
  logic [31:0] mRd, mAlu;
  logic [4:0]  mReg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void modelReset();
    mWb = '0; mRd = '0; mAlu = '0; mReg = '0;
  endfunction

  // what the MEM/WB register must hold after the coming edge
  function automatic void step(input logic [3:0] c, input logic [1:0] wb, input logic [31:0] a,
                               input logic [31:0] rdv, input logic [4:0] rg,
                               input logic bub, input logic mis);
    if (bub) mWb = 2'b00;
    else begin
      mWb  = mis ? 2'b00 : wb;
      mAlu = a;
      mReg = rg;
      if (c[1] && !c[2] && !mis) mRd = rdv;
    end
    sb.push_back('{mWb, mRd, mAlu, mReg, mis});
  endfunction

  // monitor: one MEM/WB state per cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (monEn && sb.size() > 0) begin
        e = sb.pop_front();
        chk("wb_ctrl_q", 32'(wb_ctrl_q), 32'(e.wb));
        chk("rd_data_q", rd_data_q, e.rd);
        chk("alu_q", alu_q, e.alu);
        chk("wr_reg_q", 32'(wr_reg_q), 32'(e.rg));
        chk("align_exc_o", 32'(align_exc_o), 32'(e.al));
      end
    end
  end

  // present one instruction until it leaves MEM; memory answers after lat stalled cycles
  task automatic issue(input logic [3:0] c, input logic [1:0] wb, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] rg, input logic [31:0] tgt,
                       input logic eq, input int lat, input logic [31:0] rdv);
    int   el = 0;
    bit   done = 0;
    logic acc, mis, eReq, rdy, eStall, ePc;
    while (!done) begin
      @(posedge clk); #2;
      mem_ctrl_i = c; wb_ctrl_i = wb; result_i = a; store_data_i = sd;
      wr_reg_i = rg; target_i = tgt; equal_i = eq; dmem_rdata_i = rdv;
      acc  = c[1] | c[2];
      mis  = acc && (a[1:0] != 2'b00);
      eReq = acc && !mis;
      rdy  = eReq ? (el == lat) : 1'($urandom);
      dmem_ready_i = rdy;
      #3;
      eStall = eReq && !rdy;
      ePc    = c[0] && (eq != c[3]) && !eStall;
      chk("dmem_req_o", 32'(dmem_req_o), 32'(eReq));
      chk("dmem_we_o", 32'(dmem_we_o), 32'(c[2]));
      chk("stall_o", 32'(stall_o), 32'(eStall));
      chk("pcsrc_o", 32'(pcsrc_o), 32'(ePc));
      chk("bus_err_o", 32'(bus_err_o), 32'd0);
      if (eReq) begin
        chk("dmem_addr_o", dmem_addr_o, a);
        chk("dmem_wdata_o", dmem_wdata_o, sd);
      end
      if (ePc) chk("pc_target_o", pc_target_o, tgt);
      step(c, wb, a, rdv, rg, eStall, mis);
      if (eStall) el++; else done = 1;
      if (el > 40) begin
        chk("issue_bound", 32'(el), 32'd40);
        done = 1;
      end
    end
  endtask

  initial begin
    logic [31:0] a;
    rst_n = 0; mem_ctrl_i = 0; wb_ctrl_i = 0; equal_i = 0; result_i = 0;
    store_data_i = 0; wr_reg_i = 0; target_i = 0; dmem_ready_i = 0; dmem_rdata_i = 0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst wb_ctrl_q", 32'(wb_ctrl_q), 0);
    chk("rst rd_data_q", rd_data_q, 0);
    chk("rst alu_q", alu_q, 0);
    chk("rst wr_reg_q", 32'(wr_reg_q), 0);
    chk("rst dmem_req_o", 32'(dmem_req_o), 0);
    chk("rst align_exc_o", 32'(align_exc_o), 0);
    chk("rst bus_err_o", 32'(bus_err_o), 0);
    #1 rst_n = 1;
    monEn = 1;

    // directed: zero-wait load, 3-wait store, misaligned load, branches, read+write
    issue(4'b0010, 2'b11, 32'h100, 32'h0, 5'd3, 32'h0, 1'b0, 0, 32'hDEADBEEF);
    issue(4'b0100, 2'b00, 32'h204, 32'h12345678, 5'd4, 32'h0, 1'b0, 3, 32'h0);
    issue(4'b0010, 2'b11, 32'h102, 32'h0, 5'd5, 32'h0, 1'b0, 0, 32'hCAFEF00D);
    issue(4'b0001, 2'b00, 32'h0, 32'h0, 5'd0, 32'h4000, 1'b1, 0, 32'h0);
    issue(4'b1001, 2'b00, 32'h0, 32'h0, 5'd0, 32'h5000, 1'b1, 0, 32'h0);
    issue(4'b0110, 2'b10, 32'h308, 32'hA5A5A5A5, 5'd6, 32'h0, 1'b0, 1, 32'h11111111);

    // reset in the second WAIT cycle
    @(posedge clk); #2;
    monEn = 0;
    sb.delete();
    mem_ctrl_i = 4'b0010; wb_ctrl_i = 2'b11; result_i = 32'h200; wr_reg_i = 5'd9;
    dmem_ready_i = 0;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("wait dmem_req_o", 32'(dmem_req_o), 1);
    chk("wait stall_o", 32'(stall_o), 1);
    rst_n = 0;
    #1;
    chk("midrst dmem_req_o", 32'(dmem_req_o), 0);
    chk("midrst stall_o", 32'(stall_o), 0);
    chk("midrst wb_ctrl_q", 32'(wb_ctrl_q), 0);
    chk("midrst rd_data_q", rd_data_q, 0);
    chk("midrst alu_q", alu_q, 0);
    chk("midrst wr_reg_q", 32'(wr_reg_q), 0);
    dmem_ready_i = 1; dmem_rdata_i = 32'hBAD0BAD0;
    @(posedge clk); #2;
    modelReset();
    monEn = 1;
    rst_n = 1;
    mem_ctrl_i = 4'b0000; wb_ctrl_i = 2'b00; result_i = 32'h0; wr_reg_i = 5'd0;
    #3;
    step(4'b0000, 2'b00, 32'h0, 32'hBAD0BAD0, 5'd0, 1'b0, 1'b0);
    issue(4'b0010, 2'b01, 32'h10, 32'h0, 5'd7, 32'h0, 1'b0, 0, 32'h0BADF00D);

    // randomized stream
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue(4'($urandom), 2'($urandom), a, $urandom, 5'($urandom), $urandom,
            1'($urandom), $urandom_range(0, 3), $urandom);
    end

`ifdef MEM_TIMEOUT_EN
    // memory never answers: 16 stalled cycles, abort, then one bus error pulse
    for (int c = 0; c < 19; c++) begin
      @(posedge clk); #2;
      mem_ctrl_i = (c <= 16) ? 4'b0010 : 4'b0000;
      wb_ctrl_i = 2'b11; result_i = 32'h300; wr_reg_i = 5'd8;
      dmem_ready_i = 0; dmem_rdata_i = 32'h77777777;
      #3;
      chk("to dmem_req_o", 32'(dmem_req_o), 32'(c < 16));
      chk("to stall_o", 32'(stall_o), 32'(c < 16));
      chk("to bus_err_o", 32'(bus_err_o), 32'(c == 17));
      step(mem_ctrl_i, 2'b11, 32'h300, 32'h77777777, 5'd8, c <= 16, 1'b0);
    end
`endif

    repeat (3) @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
